// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (instruction fetch, data), the
// arbiter and a single-ported synchronous memory.
interface mem_port_arbiter_if #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_SIZE  = 256
);
    localparam int AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    logic                 i_req;
    logic [AW-1:0]        i_addr;
    logic                 i_ack;
    logic                 i_rvalid;
    logic [MEM_WIDTH-1:0] i_rdata;

    logic                 d_req;
    logic                 d_we;
    logic [AW-1:0]        d_addr;
    logic [MEM_WIDTH-1:0] d_wdata;
    logic                 d_ack;
    logic                 d_rvalid;
    logic [MEM_WIDTH-1:0] d_rdata;

    logic [AW-1:0]        mem_addr;
    logic                 mem_read_en;
    logic                 mem_write_en;
    logic [MEM_WIDTH-1:0] mem_write_val;
    logic [MEM_WIDTH-1:0] mem_read_val;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_read_val,
        output i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
               mem_addr, mem_read_en, mem_write_en, mem_write_val
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_read_val,
        input  i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
               mem_addr, mem_read_en, mem_write_en, mem_write_val
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between an
// instruction-fetch and a data requester; one access per two cycles.
module mem_port_arbiter #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_SIZE  = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus,
    output logic                busy
);
    localparam int AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
    typedef enum logic {PORT_I, PORT_D} port_e;

    state_e               state_q;
    port_e                owner_q;
    port_e                last_q;
    logic                 we_q;
    logic                 i_ack_q, d_ack_q;
    logic                 i_rvalid_q, d_rvalid_q;
    logic [MEM_WIDTH-1:0] i_rdata_q, d_rdata_q;
    logic [AW-1:0]        mem_addr_q;
    logic                 rd_en_q, wr_en_q;
    logic [MEM_WIDTH-1:0] mem_wval_q;

    port_e winner;
    logic  any_req;
    logic  win_we;

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        winner = PORT_I;
        if (bus.i_req && bus.d_req) begin
            winner = (last_q == PORT_I) ? PORT_D : PORT_I;
        end else if (bus.d_req) begin
            winner = PORT_D;
        end
    end

    assign any_req = bus.i_req || bus.d_req;
    assign win_we  = (winner == PORT_D) && bus.d_we;

    // NOTE: sequential state is only ever assigned with <= so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= PORT_I;
            last_q     <= PORT_D;
            we_q       <= 1'b0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            mem_addr_q <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            mem_wval_q <= '0;
        end else begin
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;

            case (state_q)
                ISSUE: state_q <= RESP;
                RESP: begin
                    // Memory data is valid this cycle; completion is flagged next cycle.
                    if (owner_q == PORT_I) begin
                        i_rvalid_q <= 1'b1;
                        i_rdata_q  <= bus.mem_read_val;
                    end else begin
                        d_rvalid_q <= 1'b1;
                        if (!we_q) d_rdata_q <= bus.mem_read_val;
                    end
                end
                default: ;
            endcase

            // Arbitrate at the end of IDLE or RESP; a later assignment overrides the case above.
            if (state_q != ISSUE) begin
                if (any_req) begin
                    state_q    <= ISSUE;
                    owner_q    <= winner;
                    last_q     <= winner;
                    we_q       <= win_we;
                    i_ack_q    <= (winner == PORT_I);
                    d_ack_q    <= (winner == PORT_D);
                    mem_addr_q <= (winner == PORT_D) ? bus.d_addr : bus.i_addr;
                    rd_en_q    <= !win_we;
                    wr_en_q    <= win_we;
                    if (win_we) mem_wval_q <= bus.d_wdata;
                end else begin
                    state_q <= IDLE;
                end
            end
        end
    end

    assign bus.i_ack         = i_ack_q;
    assign bus.d_ack         = d_ack_q;
    assign bus.i_rvalid      = i_rvalid_q;
    assign bus.d_rvalid      = d_rvalid_q;
    assign bus.i_rdata       = i_rdata_q;
    assign bus.d_rdata       = d_rdata_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_read_en   = rd_en_q;
    assign bus.mem_write_en  = wr_en_q;
    assign bus.mem_write_val = mem_wval_q;
    assign busy              = (state_q == ISSUE) || (state_q == RESP);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: table-driven single accesses plus hand sequences for
// tie arbitration, back-to-back traffic, idle and reset during RESP.
module tb_mem_port_arbiter;
    localparam int MW = 32;
    localparam int MS = 256;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.MEM_WIDTH(MW), .MEM_SIZE(MS)) bus ();

    mem_port_arbiter #(.MEM_WIDTH(MW), .MEM_SIZE(MS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    // Synchronous single-port memory with one cycle read latency.
    logic [MW-1:0] mem [MS];
    logic [MW-1:0] rd_q;
    always @(posedge clk) begin
        if (bus.mem_write_en) mem[bus.mem_addr] <= bus.mem_write_val;
        if (bus.mem_read_en)  rd_q <= mem[bus.mem_addr];
    end
    assign bus.mem_read_val = rd_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: completions arrive in the order requests are pushed.
    typedef struct {
        logic          is_d;
        logic [MW-1:0] data;
        logic [MW-1:0] other;
    } sb_t;
    sb_t sb[$];
    logic [MW-1:0] model_i = '0;
    logic [MW-1:0] model_d = '0;

    function automatic void push(input logic is_d, input logic we, input logic [MW-1:0] rdata);
        sb_t e;
        if (!is_d) model_i = rdata;
        else if (!we) model_d = rdata;
        e.is_d  = is_d;
        e.data  = is_d ? model_d : model_i;
        e.other = is_d ? model_i : model_d;
        sb.push_back(e);
    endfunction

    sb_t got;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (bus.i_rvalid || bus.d_rvalid)) begin
            check("rvalid_exclusive", bus.i_rvalid & bus.d_rvalid, 0);
            if (sb.size() == 0) begin
                check("unexpected_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
            end else begin
                got = sb.pop_front();
                check("rvalid_port", bus.d_rvalid, got.is_d);
                check("owner_rdata", got.is_d ? bus.d_rdata : bus.i_rdata, got.data);
                check("other_rdata_stable", got.is_d ? bus.i_rdata : bus.d_rdata, got.other);
            end
        end
    end

    logic watch_busy = 1'b0;
    int   busy_low   = 0;
    always @(negedge clk) if (watch_busy && !busy) busy_low <= busy_low + 1;

    // Single access from IDLE with exact latency checks.
    task automatic access(input logic is_d, input logic we, input logic [AW-1:0] addr,
                          input logic [MW-1:0] wdata, input logic [MW-1:0] exp);
        @(negedge clk);
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        push(is_d, we, exp);
        @(posedge clk); #1;
        check("ack", is_d ? bus.d_ack : bus.i_ack, 1);
        check("other_ack", is_d ? bus.i_ack : bus.d_ack, 0);
        check("mem_addr", bus.mem_addr, addr);
        check("mem_read_en", bus.mem_read_en, !we);
        check("mem_write_en", bus.mem_write_en, we);
        if (we) check("mem_write_val", bus.mem_write_val, wdata);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(posedge clk); #1;
        check("strobes_in_resp", {bus.mem_read_en, bus.mem_write_en}, 0);
        check("busy_resp", busy, 1);
        @(posedge clk); #1;
        check("rvalid_latency", is_d ? bus.d_rvalid : bus.i_rvalid, 1);
    endtask

    task automatic wait_ack(output logic seen);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(bus.i_ack || bus.d_ack) && n < 8);
        seen = bus.i_ack || bus.d_ack;
    endtask

    typedef struct {
        logic          is_d;
        logic          we;
        logic [AW-1:0] addr;
        logic [MW-1:0] wdata;
        logic [MW-1:0] exp;
    } vec_t;
    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   prev;
        int   cnt;

        vecs[0] = '{1'b1, 1'b1, 8'h05, 32'h1234_5678, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 8'h05, 32'h0,         32'h1234_5678};
        vecs[2] = '{1'b0, 1'b0, 8'h10, 32'h0,         32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b1, 8'h20, 32'hCAFE_F00D, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 8'h20, 32'h0,         32'hCAFE_F00D};
        vecs[5] = '{1'b1, 1'b1, 8'hFF, 32'hA5A5_A5A5, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 8'hFF, 32'h0,         32'hA5A5_A5A5};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 32'h0,         32'h0000_1111};

        for (int i = 0; i < MS; i++) mem[i] = '0;
        mem[8'h10] = 32'hDEAD_BEEF;
        mem[8'h00] = 32'h0000_1111;
        for (int i = 0; i < 4; i++) mem[8'h40 + i] = 32'hB0B0_0000 + i;
        rd_q = '0;

        // Both requesters active from reset: expect I, D, I, D.
        rst_n = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 8'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h00; bus.d_wdata = '0;
        for (int g = 0; g < 4; g++) push(g[0], 1'b0, g[0] ? 32'h0000_1111 : 32'hDEAD_BEEF);
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_acks", {bus.i_ack, bus.d_ack}, 0);
        check("rst_rvalids", {bus.i_rvalid, bus.d_rvalid}, 0);
        check("rst_strobes", {bus.mem_read_en, bus.mem_write_en}, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_write_val", bus.mem_write_val, 0);
        check("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
        rst_n = 1'b1;
        prev = 0;
        for (int g = 0; g < 4; g++) begin
            wait_ack(seen);
            check("tie_ack_seen", seen, 1);
            check("tie_grant_is_d", bus.d_ack, g[0]);
            check("tie_grant_excl", bus.i_ack & bus.d_ack, 0);
            if (g > 0) check("tie_spacing", cyc - prev, 2);
            prev = cyc;
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (3) @(posedge clk);

        for (int v = 0; v < 8; v++)
            access(vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp);

        // d_req held across four addresses.
        @(negedge clk);
        bus.d_we = 1'b0; bus.d_addr = 8'h40; bus.d_req = 1'b1;
        for (int n = 0; n < 4; n++) push(1'b1, 1'b0, 32'hB0B0_0000 + n);
        for (int n = 0; n < 4; n++) begin
            wait_ack(seen);
            check("b2b_ack", bus.d_ack, 1);
            check("b2b_addr", bus.mem_addr, 8'h40 + n);
            if (n > 0) check("b2b_spacing", cyc - prev, 2);
            else watch_busy = 1'b1;
            prev = cyc;
            if (n < 3) bus.d_addr = 8'h41 + n;
            else bus.d_req = 1'b0;
        end
        @(posedge clk); #1;
        watch_busy = 1'b0;
        @(posedge clk); #1;
        check("b2b_last_rvalid", bus.d_rvalid, 1);
        check("b2b_busy_drop", busy, 0);
        check("b2b_busy_continuous", busy_low, 0);

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle_quiet", {busy, bus.mem_read_en, bus.mem_write_en}, 0);
        end

        // Reset while a fetch is in RESP.
        @(negedge clk);
        bus.i_addr = 8'h10; bus.i_req = 1'b1;
        @(posedge clk); #1;
        check("abort_ack", bus.i_ack, 1);
        bus.i_req = 1'b0;
        @(posedge clk); #1;
        check("abort_in_resp", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_rvalids", {bus.i_rvalid, bus.d_rvalid}, 0);
        check("abort_strobes", {bus.mem_read_en, bus.mem_write_en}, 0);
        check("abort_mem_addr", bus.mem_addr, 0);
        check("abort_mem_write_val", bus.mem_write_val, 0);
        check("abort_rdata", {bus.i_rdata, bus.d_rdata}, 0);
        model_i = '0;
        model_d = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.i_rvalid) cnt++;
        end
        check("abort_no_rvalid", cnt, 0);

        access(1'b0, 1'b0, 8'h20, 32'h0, 32'hCAFE_F00D);
        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter MEM_SIZE, default 256, memory depth in words; AW = $clog2(MEM_SIZE).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_req  input  1  instruction-fetch request, held until i_ack.
REQ-006 SHALL have port i_addr  input  AW  fetch address, stable while i_req high.
REQ-007 SHALL have port i_ack  output  1  fetch request accepted.
REQ-008 SHALL have port i_rvalid  output  1  one-cycle pulse, i_rdata valid.
REQ-009 SHALL have port i_rdata  output  MEM_WIDTH  fetched word.
REQ-010 SHALL have port d_req  input  1  data request, held until d_ack.
REQ-011 SHALL have port d_we  input  1  1 = write, 0 = read.
REQ-012 SHALL have port d_addr  input  AW  data address.
REQ-013 SHALL have port d_wdata  input  MEM_WIDTH  write data.
REQ-014 SHALL have port d_ack  output  1  data request accepted.
REQ-015 SHALL have port d_rvalid  output  1  one-cycle pulse, data access complete.
REQ-016 SHALL have port d_rdata  output  MEM_WIDTH  read data.
REQ-017 SHALL have port mem_addr  output  AW  shared memory address.
REQ-018 SHALL have port mem_read_en  output  1  memory read strobe.
REQ-019 SHALL have port mem_write_en  output  1  memory write strobe.
REQ-020 SHALL have port mem_write_val  output  MEM_WIDTH  memory write data.
REQ-021 SHALL have port mem_read_val  input  MEM_WIDTH  memory read data, valid the cycle after address/read_en sampled (synchronous, 1-cycle latency).
REQ-022 SHALL have port busy  output  1  high in ISSUE or RESP.

Function
REQ-023 SHALL implement FSM states IDLE, ISSUE, RESP; all outputs registered or decoded from registered state only.
REQ-024 Arbitration point: end of IDLE or end of RESP; if any req high, latch winner's addr/we/wdata and owner, go to ISSUE; else go to IDLE.
REQ-025 Arbitration SHALL be round-robin: single request wins; both requesting -> port not served last wins; last_served resets to D so I wins first tie.
REQ-026 In ISSUE: ack of owner = 1 (exactly one cycle), mem_addr = latched addr; read -> mem_read_en = 1, mem_write_en = 0; write -> mem_write_en = 1, mem_write_val = latched wdata, mem_read_en = 0; next state RESP unconditionally.
REQ-027 Outside ISSUE: mem_read_en = 0, mem_write_en = 0; mem_addr, mem_write_val hold last value.
REQ-028 In RESP: on read, mem_read_val captured into owner's rdata at end of cycle; owner's rvalid pulses the following cycle for exactly one cycle.
REQ-029 Write completion: d_rvalid pulses at same relative cycle as a read; d_rdata unchanged.
REQ-030 Latency: request sampled at edge k -> ack in cycle k+1 -> memory data cycle k+2 -> rvalid/rdata cycle k+3.
REQ-031 Back-to-back: RESP -> ISSUE direct when a request pending; sustained throughput one access per 2 cycles; rvalid of access n overlaps ISSUE of access n+1.
REQ-032 Requester SHALL deassert req or present a new request after ack; a req still high in the cycle after ack counts as a new request.
REQ-033 The owner's rdata of the non-owner SHALL never change; i_rvalid and d_rvalid never high together.

Reset
REQ-034 rst_n low SHALL asynchronously force state = IDLE, last_served = D, all acks/rvalids/strobes/busy = 0, mem_addr = 0, mem_write_val = 0, i_rdata = 0, d_rdata = 0.
REQ-035 Reset mid-access SHALL abort the access: no rvalid issued afterward; first access after release starts from IDLE.

Verification
REQ-036 Single fetch: i_req=1, i_addr=0x10, mem[0x10]=0xDEADBEEF -> i_ack cycle k+1, mem_read_en=1 with mem_addr=0x10, i_rvalid=1 and i_rdata=0xDEADBEEF cycle k+3.
REQ-037 Tie: i_req and d_req both high from reset -> I granted first, D second (ISSUE two cycles later), then alternation I, D, I, D under sustained requests.
REQ-038 Write then read: d_we=1, d_addr=0x05, d_wdata=0x12345678 -> mem_write_en=1 one cycle, d_rdata unchanged; then read 0x05 -> d_rdata=0x12345678.
REQ-039 Back-to-back: d_req held with 4 addresses -> 4 acks spaced 2 cycles apart, 4 d_rvalid pulses in order, busy continuously high.
REQ-040 Reset in RESP: assert rst_n=0 during RESP of fetch -> all outputs 0 immediately, no i_rvalid after release.
REQ-041 Idle: no requests for 10 cycles -> mem_read_en = mem_write_en = 0, busy = 0 throughout.
